// File: rtl/tensor_pkg.sv
// Shared types and helpers for the 3D tensor loader.
//   state_t     : loader FSM states (LOAD while filling, READY while serving)
//   safe_clog2  : clog2 that never returns less than 1, for counter widths
//   slice_off   : bit offset of element (r,c) inside a packed channel slice
package tensor_pkg;

    typedef enum logic {
        LOAD  = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int slice_off(input int r, input int c, input int dim2, input int w);
        return (r * dim2 + c) * w;
    endfunction

endpackage

// File: rtl/tensor_idx_counter.sv
// Nested col/row/ch index counter: col runs fastest, then row, then ch.
// Each counter wraps to zero after its last value.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   en       : advance by one element
//   clr      : synchronous return to element 0 (wins over en)
//   col/row/ch : current element coordinates
//   last     : high while the coordinates point at the final element
module tensor_idx_counter
    import tensor_pkg::*;
#(
    parameter int DIM1  = 2,
    parameter int DIM2  = 2,
    parameter int DIM3  = 6,
    parameter int COL_W = safe_clog2(DIM2),
    parameter int ROW_W = safe_clog2(DIM1),
    parameter int CH_W  = safe_clog2(DIM3)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic [CH_W-1:0]  ch,
    output logic             last
);

    logic col_end;
    logic row_end;
    logic ch_end;

    assign col_end = (col == COL_W'(DIM2 - 1));
    assign row_end = (row == ROW_W'(DIM1 - 1));
    assign ch_end  = (ch  == CH_W'(DIM3 - 1));
    assign last    = col_end && row_end && ch_end;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col <= '0;
            row <= '0;
            ch  <= '0;
        end else if (en) begin
            if (col_end) begin
                col <= '0;
                if (row_end) begin
                    row <= '0;
                    ch  <= ch_end ? '0 : ch + CH_W'(1);
                end else begin
                    row <= row + ROW_W'(1);
                end
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/tensor3d_loader.sv
// Streams DATA_W-bit words into a DIM3 x DIM1 x DIM2 register tensor, then
// serves whole channel slices with one cycle of latency. clear restarts
// loading without touching stored contents, so filters can be swapped.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   clear                : restart loading (priority over handshake and read)
//   in_valid/in_data/in_ready : element input stream
//   load_done, load_count: load status
//   rd_req, rd_ch        : slice request
//   out_valid, out_ch, out_slice : slice response (element (r,c) at (r*DIM2+c)*DATA_W)
//   rd_err               : request rejected
// Handshake: an element transfers on a rising edge where in_valid and
// in_ready are both high; in_valid may rise before in_ready and in_data must
// stay stable while in_valid waits. in_ready is high exactly while in LOAD.
module tensor3d_loader
    import tensor_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DIM1   = 2,
    parameter int DIM2   = 2,
    parameter int DIM3   = 6,
    localparam int N_ELEM = DIM1 * DIM2 * DIM3,
    localparam int CH_W   = safe_clog2(DIM3),
    localparam int CNT_W  = $clog2(N_ELEM + 1),
    localparam int SW     = DIM1 * DIM2 * DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              load_done,
    output logic [CNT_W-1:0]  load_count,
    input  logic              rd_req,
    input  logic [CH_W-1:0]   rd_ch,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [SW-1:0]     out_slice,
    output logic              rd_err
);

    localparam int COL_W = safe_clog2(DIM2);
    localparam int ROW_W = safe_clog2(DIM1);

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] mem [N_ELEM];

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [CH_W-1:0]  ch;
    logic             last;

    logic             accept;
    logic [CNT_W-1:0] wr_idx;
    logic             ch_ok;
    logic [CH_W-1:0]  rd_sel;
    logic             rd_ok;
    logic [SW-1:0]    slice;

    // A beat offered in the same cycle as clear is dropped.
    assign accept   = (state == LOAD) && in_valid && !clear;
    assign in_ready = (state == LOAD);
    assign load_done = (state == READY);

    assign wr_idx = CNT_W'(int'(ch) * DIM1 * DIM2 + int'(row) * DIM2 + int'(col));

    tensor_idx_counter #(
        .DIM1  (DIM1),
        .DIM2  (DIM2),
        .DIM3  (DIM3),
        .COL_W (COL_W),
        .ROW_W (ROW_W),
        .CH_W  (CH_W)
    ) u_idx (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .clr  (clear),
        .col  (col),
        .row  (row),
        .ch   (ch),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = LOAD;
        end else if (accept && last) begin
            state_next = READY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            load_count <= '0;
        end else if (accept) begin
            load_count <= load_count + CNT_W'(1);
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mem[wr_idx] <= in_data;
        end
    end

    // Out-of-range channels are steered to 0 only to keep the mux index legal;
    // such requests are rejected and never update out_slice.
    assign ch_ok  = ({1'b0, rd_ch} < (CH_W + 1)'(DIM3));
    assign rd_sel = ch_ok ? rd_ch : '0;
    assign rd_ok  = rd_req && (state == READY) && !clear && ch_ok;

    always_comb begin
        slice = '0;
        for (int r = 0; r < DIM1; r++) begin
            for (int c = 0; c < DIM2; c++) begin
                slice[slice_off(r, c, DIM2, DATA_W) +: DATA_W] =
                    mem[CNT_W'(int'(rd_sel) * DIM1 * DIM2 + r * DIM2 + c)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            rd_err    <= 1'b0;
            out_ch    <= '0;
            out_slice <= '0;
        end else begin
            out_valid <= rd_ok;
            rd_err    <= rd_req && !rd_ok;
            if (rd_ok) begin
                out_ch    <= rd_ch;
                out_slice <= slice;
            end
        end
    end

endmodule

// File: doc/tensor3d_loader.md
Name: tensor3d_loader

Overview:
- Sequential successor to the static file-backed 3D array loader.
- Receives a stream of DATA_W-bit words (e.g. IEEE-754 filter weights) over a valid/ready handshake and stores them as a DIM3 x DIM1 x DIM2 tensor.
- Once fully loaded, serves whole 2D channel slices to the convolution engine on request, with 1-cycle latency.
- Supports re-load (clear) without reset, so filters can be swapped between layers.

Parameters:
- DATA_W, 32, element width in bits
- DIM1, 2, rows per channel slice
- DIM2, 2, columns per channel slice
- DIM3, 6, channel count
- (derived) N_ELEM = DIM1*DIM2*DIM3; CH_W = max(1, clog2(DIM3)); CNT_W = clog2(N_ELEM+1)

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous restart of loading; storage contents are kept
- in_valid  in  1  in_data is valid
- in_data  in  DATA_W  next tensor element
- in_ready  out  1  block accepts an element (high only in LOAD)
- load_done  out  1  level; tensor is fully loaded (high only in READY)
- load_count  out  CNT_W  number of elements accepted since the last rst/clear
- rd_req  in  1  single-cycle request for one channel slice
- rd_ch  in  CH_W  requested channel index
- out_valid  out  1  1-cycle pulse; out_slice is valid
- out_ch  out  CH_W  channel index of the slice being returned
- out_slice  out  DIM1*DIM2*DATA_W  element (r,c) at bits [(r*DIM2+c)*DATA_W +: DATA_W]
- rd_err  out  1  1-cycle pulse; request rejected

Behaviour:
- Reset (rst=1): state=LOAD, counters=0, load_count=0, load_done=0, out_valid=0, rd_err=0, out_ch=0, out_slice=0. Storage is not reset. in_ready=1 in the cycle after reset is released.
- States:
  - LOAD: in_ready=1. Each cycle with in_valid&in_ready, in_data is written at linear index ch*DIM1*DIM2 + row*DIM2 + col (col fastest, then row, then ch). Counters col/row/ch advance with wrap, and load_count increments.
  - LOAD -> READY: on acceptance of element N_ELEM-1. Starting the next cycle, in_ready=0 and load_done=1.
  - READY: in_ready=0, so further in_valid is ignored and nothing is written. load_done holds at 1 until clear or rst.
- Clear: clear=1 in any state -> next cycle state=LOAD, counters=0, load_count=0, load_done=0. An element presented in the same cycle as clear is NOT written. Clear has priority over handshake and read.
- Read, normal: rd_req=1 in READY with rd_ch<DIM3 -> next cycle out_valid=1, out_ch=rd_ch, out_slice=registered copy of that channel. Back-to-back requests are allowed, one slice per cycle.
- Read, rejected: rd_req with rd_ch>=DIM3, or rd_req in LOAD (including the cycle that accepts the last element), or rd_req coincident with clear -> next cycle rd_err=1, out_valid=0, out_slice/out_ch hold their previous values.
- out_valid and rd_err are never high together. Both are 0 in any cycle after a cycle without rd_req.
- rst mid-operation overrides everything, including a pending read, whose response is suppressed.
- Storage: DIM3*DIM1*DIM2 registers of DATA_W bits (register array, not RAM), so a full slice can be read in a single cycle.

Decomposition:
- Package tensor_pkg holds:
  - state enum (LOAD, READY)
  - safe clog2 function (returns >=1)
  - slice-packing index function (r,c)->bit offset
- One sub-module: tensor_idx_counter, a parametrised nested col/row/ch counter.
  - Inputs: en, clr.
  - Outputs: col, row, ch, last (high when at the final element).

Test Plan:
1. Defaults. Stream 24 words 0x3F800000+k, k=0..23, with in_valid constantly high. Required: in_ready drops the cycle after the 24th accept; load_done=1; load_count=24. rd_req ch=0 -> next cycle out_valid=1 with slice {k=3,2,1,0}. rd_req ch=5 -> slice {23,22,21,20}.
2. Gaps. in_valid toggling 1010…, plus a 25th word presented after load completes. Required: only valid&ready beats are counted and stored; the 25th word is ignored; reads match test 1.
3. Bad channel. rd_req rd_ch=6 in READY -> rd_err pulse for 1 cycle, out_valid=0, out_slice unchanged. Back-to-back rd_ch=1,2 -> consecutive out_valid with correct slices.
4. Read too early. rd_req during LOAD, and again in the same cycle as the last element accept -> rd_err both times, no out_valid.
5. Clear mid-load. Assert clear after 10 accepts, with in_valid high in the clear cycle. Required: load_count=0 next cycle and the clear-cycle word is not stored. Reload 24 words 0x40000000+k; a read of ch=2 returns {0x4000000B..0x40000008}.
6. Reset. Assert rst in the same cycle as rd_req in READY. Required: no out_valid; state returns to LOAD; load_done=0; in_ready=1 one cycle after rst is released.
